// File: rtl/ysyx_lsu_pkg.sv
// Shared types for the load/store unit: store-queue entry layout, size codes
// and the drain FSM state encoding.
package ysyx_lsu_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] SQ_SB = 5'd0;
    localparam logic [4:0] SQ_SH = 5'd1;
    localparam logic [4:0] SQ_SW = 5'd2;

    typedef struct packed {
        logic            valid;
        logic [4:0]      alu;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
    } sq_entry_t;

    typedef enum logic {
        SQ_IDLE,
        SQ_BUSY
    } sq_state_e;

endpackage

// File: rtl/ysyx_lsu_sq_lane.sv
// Byte-lane formation for a 32-bit bus: turns size code + byte address + LSB-aligned
// data into a word address, lane-shifted data and byte strobes.
module ysyx_lsu_sq_lane
    import ysyx_lsu_pkg::*;
(
    input  logic [4:0]      alu,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] awaddr,
    output logic [XLEN-1:0] wdata,
    output logic [7:0]      wstrb,
    output logic            misaligned
);

    logic [1:0] off;
    logic [4:0] shamt;

    assign off   = addr[1:0];
    assign shamt = {off, 3'b000};

    always_comb begin
        awaddr     = {addr[XLEN-1:2], 2'b00};
        wdata      = data;
        wstrb      = 8'h00;
        misaligned = 1'b0;
        case (alu)
            SQ_SB: begin
                wstrb = 8'h01 << off;
                wdata = {{(XLEN-8){1'b0}}, data[7:0]} << shamt;
            end
            SQ_SH: begin
                wstrb      = 8'h03 << off;
                wdata      = {{(XLEN-16){1'b0}}, data[15:0]} << shamt;
                misaligned = off[0];
            end
            SQ_SW: begin
                wstrb      = 8'h0f;
                misaligned = (off != 2'b00);
            end
            // unknown size codes issue no strobes and are flagged
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_lsu_sq.sv
// Committed-store queue: buffers retired stores in order and drains them one at a
// time on the aw/w channel, flagging word-address conflicts for younger loads.
//
//   state   | meaning
//   SQ_IDLE | no bus transfer in flight; loads head entry when queue non-empty
//   SQ_BUSY | head entry presented on aw/w, waiting for wready
module ysyx_lsu_sq
    import ysyx_lsu_pkg::*;
#(
    parameter int SQ_SIZE = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            rou_valid,
    input  logic            rou_store,
    input  logic [4:0]      rou_alu,
    input  logic [XLEN-1:0] rou_sq_waddr,
    input  logic [XLEN-1:0] rou_sq_wdata,
    input  logic [XLEN-1:0] rou_pc,
    output logic            sq_ready,
    output logic            sq_empty,
    output logic            awvalid,
    output logic [XLEN-1:0] awaddr,
    output logic            wvalid,
    output logic [XLEN-1:0] wdata,
    output logic [7:0]      wstrb,
    input  logic            wready,
    input  logic [XLEN-1:0] ld_addr,
    output logic            ld_conflict
);

    localparam int PW = $clog2(SQ_SIZE);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(SQ_SIZE);

    sq_entry_t       entries [SQ_SIZE];
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count;
    sq_state_e       state, state_nxt;
    logic            enq, pop, load;
    logic [XLEN-1:0] lane_addr, lane_data;
    logic [7:0]      lane_strb;
    logic            lane_bad;
    logic            unused_bits;

    // ready is based on the registered count, so a full queue refuses even while popping
    assign sq_ready = (count != FULL);
    assign sq_empty = (count == '0) && (state == SQ_IDLE);
    assign enq      = rou_valid & rou_store & sq_ready;
    assign load     = (state == SQ_IDLE) && (count != '0);
    assign pop      = (state == SQ_BUSY) && wready;
    assign wvalid   = awvalid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= SQ_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SQ_IDLE: if (count != '0) state_nxt = SQ_BUSY;
            SQ_BUSY: if (wready)      state_nxt = SQ_IDLE;
            default:                  state_nxt = SQ_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // tail==head with a live head entry only when full, and enq is blocked then
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SQ_SIZE; i++) entries[i] <= '0;
        end else begin
            if (enq) entries[tail] <= '{valid: 1'b1, alu: rou_alu, addr: rou_sq_waddr,
                                        data: rou_sq_wdata, pc: rou_pc};
            if (pop) entries[head].valid <= 1'b0;
        end
    end

    ysyx_lsu_sq_lane u_lane (
        .alu        (entries[head].alu),
        .addr       (entries[head].addr),
        .data       (entries[head].data),
        .awaddr     (lane_addr),
        .wdata      (lane_data),
        .wstrb      (lane_strb),
        .misaligned (lane_bad)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            awvalid <= 1'b0;
            awaddr  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
        end else if (load) begin
            awvalid <= 1'b1;
            awaddr  <= lane_addr;
            wdata   <= lane_data;
            wstrb   <= lane_strb;
        end else if (pop) begin
            awvalid <= 1'b0;
        end
    end

    // the BUSY entry stays valid until its wready edge, so it keeps blocking loads
    always_comb begin
        ld_conflict = 1'b0;
        for (int i = 0; i < SQ_SIZE; i++) begin
            if (entries[i].valid && (entries[i].addr[XLEN-1:2] == ld_addr[XLEN-1:2]))
                ld_conflict = 1'b1;
        end
    end

    always_comb begin
        unused_bits = ^ld_addr[1:0];
        for (int i = 0; i < SQ_SIZE; i++) unused_bits = unused_bits ^ (^entries[i].pc);
    end

    a_lane_aligned: assert property (@(posedge clock) disable iff (reset) load |-> !lane_bad);

endmodule
